add_sequencer: RTL
==================

# add_sequencer

Sequential front/back end for the `genAdder` ripple-carry adder. Latches operand A, then operand B, from a shared N-bit input bus on successive `load` rising edges. Drives both operands into an internal `genAdder`, registers the (N+1)-bit result and keeps a sticky overflow flag. Optionally chains the previous sum in as the next A, so a board-level switch/button front end can run multi-operand additions.

## Interface
Parameters:
- `N`, 9, operand width in bits (N ≥ 2).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; **synchronous, active-high**.
- `din`  in  N  operand bus (switches).
- `load`  in  1  level strobe (synchronized, debounced button); only its rising edge acts.
- `chain`  in  1  sampled with a `load` edge in DONE: 1 = previous `result[N-1:0]` becomes A and `din` becomes B.
- `result`  out  N+1  registered `{cout, sum}` of the last completed addition.
- `done`  out  1  high while in DONE.
- `ovf`  out  1  sticky: set when any completed addition has cout=1; cleared only by `rst`.
- `state`  out  2  current FSM state, for LEDs.

## Operation
- Edge detect: `load_q` samples `load` every cycle, including during `rst`. `ld_evt = load & ~load_q`. A `load` held through reset release gives no event.
- States (encoding): IDLE=2'd0, HAVE_A=2'd1, CALC=2'd2, DONE=2'd3.
- IDLE: on `ld_evt`, `a_reg <= din` and go to HAVE_A.
- HAVE_A: on `ld_evt`, `b_reg <= din` and go to CALC.
- CALC: unconditional, one cycle. `result <= {cout, sum}` from `genAdder(a_reg, b_reg)`; `ovf <= ovf | cout`. Go to DONE. `ld_evt` in CALC is ignored (dropped, not queued).
- DONE: on `ld_evt` with `chain=0`: `a_reg <= din`, go to HAVE_A, and `result` is held. On `ld_evt` with `chain=1`: `a_reg <= result[N-1:0]`, `b_reg <= din`, go to CALC. The carry bit of the previous result is discarded; it is already captured in `ovf`.
- Arithmetic: `result = a + b` modulo 2^(N+1). It must equal `{cout, sum}` from `genAdder` bit-exactly.
- Reset (any state, any cycle): state=IDLE; `a_reg`, `b_reg` = 0; `result` = 0; `done` = 0; `ovf` = 0; `state` = 2'd0. Reset wins over a simultaneous `ld_evt`.

## Timing
- `ld_evt` is registered in the cycle after `load` rises. The state and operand registers update on that same edge.
- Latency from the B-load edge to a valid `result` is 2 clock edges: edge 1 enters CALC, edge 2 registers `result` and sets `done`.
- Chained op: `result` is updated 2 edges after the `load` edge in DONE.
- `done` is a registered decode of state==DONE. It drops on the edge that leaves DONE.
- `result` changes only on the CALC→DONE edge or on `rst`.
- Combinational adder path: `a_reg`/`b_reg` → `genAdder` → `result` register. This is one full ripple within one `clk` period.

## Structure
- Package `adder_pkg`: state localparams (IDLE, HAVE_A, CALC, DONE) and the state width constant (2).
- Sub-module: one instance of the existing `genAdder #(.N(N))` with ports `a`, `b`, `sum`, `cout`. No adder logic is duplicated in this block.
- Everything else (edge detect, FSM, operand and result registers) lives in `add_sequencer`.

## Test plan
- Reset then basic add, N=9: loads 300 then 200 → after 2 edges, `result`=10'd500, `done`=1, `ovf`=0, `state`=3.
- Carry out: 511 + 1 → `result`=10'd512 (cout=1), `ovf`=1. Then 3 + 4 → `result`=10'd7 with `ovf` still 1.
- Chain: 100 + 50 → 150. Then `chain`=1 with `din`=400 → `result`=10'd550 and `ovf`=1.
- Held/edge behaviour: hold `load` high for 10 cycles → exactly one operand latched. Pulse `load` during CALC → ignored, and `result` is correct for the original operands.
- Reset mid-operation: assert `rst` in HAVE_A with `load` rising in the same cycle → `state`=0, `result`=0, `ovf`=0, `done`=0. Holding `load` through reset release produces no event.
- Exhaustive sweep, N=4: all 256 (a,b) pairs via IDLE→HAVE_A→CALC → `result` == a+b every time, zero mismatches.

Source files
------------

// File: rtl/adder_pkg.sv
// State encoding and widths shared by the add sequencer and its bench.
// Pure declarations, no logic.
package adder_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        HAVE_A = 2'd1,
        CALC   = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/add_sequencer_gen_adder.sv
// N-bit ripple-carry adder: sum and carry-out of a + b, no carry-in.
// Latency: purely combinational; backpressure: none.
module genAdder #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic carry;

    // The carry is walked LSB to MSB so the chain is a true ripple.
    always_comb begin
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/add_sequencer.sv
// Loads A then B from a shared bus on load rising edges and registers {cout, sum}.
// Latency: result 2 edges after the B (or chained) load edge; backpressure: none, load edges in CALC are dropped.
module add_sequencer
    import adder_pkg::*;
#(
    parameter int N = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        din,
    input  logic                load,
    input  logic                chain,
    output logic [N:0]          result,
    output logic                done,
    output logic                ovf,
    output logic [STATE_W-1:0]  state
);

    state_e       state_q, state_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [N:0]   result_q, result_d;
    logic         ovf_q, ovf_d;
    logic         done_q, done_d;
    logic         load_q;
    logic         ld_evt;
    logic [N-1:0] add_sum;
    logic         add_cout;

    genAdder #(.N(N)) u_adder (
        .a    (a_q),
        .b    (b_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign ld_evt = load & ~load_q;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (ld_evt) begin
                    a_d     = din;
                    state_d = HAVE_A;
                end
            end
            HAVE_A: begin
                if (ld_evt) begin
                    b_d     = din;
                    state_d = CALC;
                end
            end
            CALC: begin
                result_d = {add_cout, add_sum};
                ovf_d    = ovf_q | add_cout;
                state_d  = DONE;
            end
            DONE: begin
                if (ld_evt) begin
                    // Chaining drops the old carry; it already lives in ovf.
                    if (chain) begin
                        a_d     = result_q[N-1:0];
                        b_d     = din;
                        state_d = CALC;
                    end else begin
                        a_d     = din;
                        state_d = HAVE_A;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
    end

    // load_q keeps tracking during reset so a held button gives no edge on release.
    always_ff @(posedge clk) begin
        load_q <= load;
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign ovf    = ovf_q;
    assign state  = state_q;

endmodule
